// File: rtl/ofdm_rx_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ofdm_rx_ctrl_pkg
//  Description : Shared state encoding and sizing helpers for the OFDM RX
//                symbol sequencer and its watchdog.
//  Revision    : 1.0  initial release
// ============================================================================
package ofdm_rx_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_SYNC = 2'd1,
        ST_GUARD     = 2'd2,
        ST_DATA      = 2'd3
    } seq_state_t;

    function automatic int unsigned guard_len(input int unsigned raw_len,
                                              input int unsigned sym_len);
        return raw_len - sym_len;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ofdm_rx_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : ofdm_rx_watchdog
//  Description : Idle-cycle counter; flags a timeout after TIMEOUT cycles
//                without a clear while enabled.
//  Revision    : 1.0  initial release
// ============================================================================
module ofdm_rx_watchdog
    import ofdm_rx_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_timeout
);

    localparam int unsigned    c_W     = cnt_width(TIMEOUT + 1);
    localparam logic [c_W-1:0] c_LIMIT = c_W'(TIMEOUT);

    logic [c_W-1:0] r_count;
    logic           w_expired;

    // A clear in the limit cycle wins, so a late strobe never times out.
    assign w_expired = i_enable && !i_clear && (r_count == c_LIMIT);
    assign o_timeout = w_expired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear || !i_enable || w_expired) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ofdm_rx_symbol_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ofdm_rx_symbol_sequencer
//  Description : Strips the cyclic prefix after sync, forwards useful samples
//                to the FFT with index qualifiers and supervises lock/overflow.
//  Revision    : 1.0  initial release
// ============================================================================
module ofdm_rx_symbol_sequencer
    import ofdm_rx_ctrl_pkg::*;
#(
    parameter int unsigned symbol_length_g     = 64,
    parameter int unsigned raw_symbol_length_g = 80,
    parameter int unsigned symbols_per_frame_g = 3,
    parameter int unsigned timeout_g           = 256
) (
    input  logic                                         sys_clk,
    input  logic                                         sys_rstn,
    input  logic                                         sys_init,
    input  logic                                         rx_data_valid,
    input  logic                                         sync_detect,
    input  logic                                         fft_busy,
    output logic                                         fft_start,
    output logic                                         fft_sample_valid,
    output logic [cnt_width(symbol_length_g)-1:0]        sample_idx,
    output logic [cnt_width(symbols_per_frame_g+1)-1:0]  symbol_idx,
    output logic                                         rx_rcv_data_start,
    output logic                                         frame_done,
    output logic                                         lost_lock,
    output logic                                         overflow_err
);

    localparam int unsigned c_GUARD = guard_len(raw_symbol_length_g, symbol_length_g);
    localparam int unsigned c_CW    = cnt_width(raw_symbol_length_g);
    localparam int unsigned c_SW    = cnt_width(symbol_length_g);
    localparam int unsigned c_YW    = cnt_width(symbols_per_frame_g + 1);

    localparam logic [c_CW-1:0] c_GUARD_LAST = c_CW'(c_GUARD - 1);
    localparam logic [c_CW-1:0] c_DATA_LAST  = c_CW'(symbol_length_g - 1);
    localparam logic [c_YW-1:0] c_SYM_LAST   = c_YW'(symbols_per_frame_g - 1);

    seq_state_t        r_state;
    logic [c_CW-1:0]   r_sample_cnt;
    logic [c_YW-1:0]   r_symbol_cnt;
    logic              r_fft_start;
    logic              r_fft_sample_valid;
    logic [c_SW-1:0]   r_sample_idx;
    logic [c_YW-1:0]   r_symbol_idx;
    logic              r_rx_rcv_data_start;
    logic              r_frame_done;
    logic              r_lost_lock;
    logic              r_overflow_err;

    logic              w_wd_enable;
    logic              w_wd_clear;
    logic              w_timeout;

    assign w_wd_enable = (r_state == ST_GUARD) || (r_state == ST_DATA);
    assign w_wd_clear  = rx_data_valid || sys_init;

    ofdm_rx_watchdog #(
        .TIMEOUT (timeout_g)
    ) u_watchdog (
        .clk       (sys_clk),
        .rst_n     (sys_rstn),
        .i_clear   (w_wd_clear),
        .i_enable  (w_wd_enable),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            r_state             <= ST_IDLE;
            r_sample_cnt        <= '0;
            r_symbol_cnt        <= '0;
            r_fft_start         <= 1'b0;
            r_fft_sample_valid  <= 1'b0;
            r_sample_idx        <= '0;
            r_symbol_idx        <= '0;
            r_rx_rcv_data_start <= 1'b0;
            r_frame_done        <= 1'b0;
            r_lost_lock         <= 1'b0;
            r_overflow_err      <= 1'b0;
        end else begin
            r_fft_start         <= 1'b0;
            r_fft_sample_valid  <= 1'b0;
            r_rx_rcv_data_start <= 1'b0;
            r_frame_done        <= 1'b0;
            r_lost_lock         <= 1'b0;

            if (sys_init) begin
                r_state        <= ST_WAIT_SYNC;
                r_sample_cnt   <= '0;
                r_symbol_cnt   <= '0;
                r_sample_idx   <= '0;
                r_symbol_idx   <= '0;
                r_overflow_err <= 1'b0;
            end else if (w_timeout) begin
                r_state      <= ST_WAIT_SYNC;
                r_sample_cnt <= '0;
                r_symbol_cnt <= '0;
                r_sample_idx <= '0;
                r_symbol_idx <= '0;
                r_lost_lock  <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                    end
                    ST_WAIT_SYNC: begin
                        // The sync sample itself is guard sample 0.
                        if (rx_data_valid && sync_detect) begin
                            r_state      <= (c_GUARD == 1) ? ST_DATA : ST_GUARD;
                            r_sample_cnt <= (c_GUARD == 1) ? '0 : c_CW'(1);
                            r_symbol_cnt <= '0;
                            r_sample_idx <= '0;
                            r_symbol_idx <= '0;
                        end
                    end
                    ST_GUARD: begin
                        if (rx_data_valid) begin
                            if (r_sample_cnt == c_GUARD_LAST) begin
                                r_state      <= ST_DATA;
                                r_sample_cnt <= '0;
                            end else begin
                                r_sample_cnt <= r_sample_cnt + c_CW'(1);
                            end
                        end
                    end
                    ST_DATA: begin
                        if (rx_data_valid) begin
                            r_fft_sample_valid  <= 1'b1;
                            r_sample_idx        <= r_sample_cnt[c_SW-1:0];
                            r_symbol_idx        <= r_symbol_cnt;
                            r_fft_start         <= (r_sample_cnt == '0);
                            r_rx_rcv_data_start <= (r_symbol_cnt == '0);
                            if ((r_sample_cnt == '0) && fft_busy) begin
                                r_overflow_err <= 1'b1;
                            end
                            if (r_sample_cnt == c_DATA_LAST) begin
                                r_sample_cnt <= '0;
                                if (r_symbol_cnt == c_SYM_LAST) begin
                                    r_frame_done <= 1'b1;
                                    r_state      <= ST_WAIT_SYNC;
                                end else begin
                                    r_symbol_cnt <= r_symbol_cnt + c_YW'(1);
                                    r_state      <= ST_GUARD;
                                end
                            end else begin
                                r_sample_cnt <= r_sample_cnt + c_CW'(1);
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign fft_start         = r_fft_start;
    assign fft_sample_valid  = r_fft_sample_valid;
    assign sample_idx        = r_sample_idx;
    assign symbol_idx        = r_symbol_idx;
    assign rx_rcv_data_start = r_rx_rcv_data_start;
    assign frame_done        = r_frame_done;
    assign lost_lock         = r_lost_lock;
    assign overflow_err      = r_overflow_err;

endmodule
`default_nettype wire

// File: tb/tb_ofdm_rx_symbol_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ofdm_rx_symbol_sequencer
//  Description : Self-checking bench: scenario table, corner sequences and a
//                randomized run against a sample-position reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ofdm_rx_symbol_sequencer;

    localparam int N   = 64;
    localparam int RAW = 80;
    localparam int G   = RAW - N;
    localparam int SPF = 3;
    localparam int TO  = 256;

    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_LOCK = 2;

    logic       sys_clk;
    logic       sys_rstn;
    logic       sys_init;
    logic       rx_data_valid;
    logic       sync_detect;
    logic       fft_busy;
    logic       fft_start;
    logic       fft_sample_valid;
    logic [5:0] sample_idx;
    logic [1:0] symbol_idx;
    logic       rx_rcv_data_start;
    logic       frame_done;
    logic       lost_lock;
    logic       overflow_err;

    ofdm_rx_symbol_sequencer #(
        .symbol_length_g     (N),
        .raw_symbol_length_g (RAW),
        .symbols_per_frame_g (SPF),
        .timeout_g           (TO)
    ) dut (
        .sys_clk           (sys_clk),
        .sys_rstn          (sys_rstn),
        .sys_init          (sys_init),
        .rx_data_valid     (rx_data_valid),
        .sync_detect       (sync_detect),
        .fft_busy          (fft_busy),
        .fft_start         (fft_start),
        .fft_sample_valid  (fft_sample_valid),
        .sample_idx        (sample_idx),
        .symbol_idx        (symbol_idx),
        .rx_rcv_data_start (rx_rcv_data_start),
        .frame_done        (frame_done),
        .lost_lock         (lost_lock),
        .overflow_err      (overflow_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Event counters observed from the DUT, reset per scenario.
    int cnt_valid, cnt_start, cnt_rds, cnt_fd, cnt_ll;

    // Reference model: position of each strobe since sync decides everything.
    int         m_mode, m_pos, m_idle;
    logic       e_start, e_valid, e_rds, e_fd, e_ll, e_ovf;
    logic [5:0] e_sidx;
    logic [1:0] e_sym;

    typedef struct {
        int gap;
        int sync_at;
        int nstrobe;
        int busy_sym;
        int exp_valid;
        int exp_start;
        int exp_rds;
        int exp_fd;
        int exp_ovf;
    } scen_t;

    scen_t vec [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [13:0] pack_dut();
        return {fft_start, fft_sample_valid, sample_idx, symbol_idx,
                rx_rcv_data_start, frame_done, lost_lock, overflow_err};
    endfunction

    function automatic logic [13:0] pack_exp();
        return {e_start, e_valid, e_sidx, e_sym, e_rds, e_fd, e_ll, e_ovf};
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_pos = 0; m_idle = 0;
        e_start = 0; e_valid = 0; e_rds = 0; e_fd = 0; e_ll = 0; e_ovf = 0;
        e_sidx = '0; e_sym = '0;
    endtask

    task automatic model(input logic v, input logic s, input logic b, input logic init);
        int off, symn, idx;
        e_start = 0; e_valid = 0; e_rds = 0; e_fd = 0; e_ll = 0;
        if (init) begin
            m_mode = M_WAIT; m_pos = 0; m_idle = 0; e_ovf = 0; e_sidx = '0; e_sym = '0;
        end else if (m_mode == M_WAIT) begin
            if (v && s) begin
                m_mode = M_LOCK; m_pos = 1; m_idle = 0; e_sidx = '0; e_sym = '0;
            end
        end else if (m_mode == M_LOCK) begin
            if (v) begin
                off  = m_pos % RAW;
                symn = m_pos / RAW;
                if (off >= G) begin
                    idx     = off - G;
                    e_valid = 1;
                    e_sidx  = 6'(idx);
                    e_sym   = 2'(symn);
                    e_start = (idx == 0);
                    e_rds   = (symn == 0);
                    if (idx == 0 && b) e_ovf = 1;
                    if (symn == SPF - 1 && idx == N - 1) begin
                        e_fd   = 1;
                        m_mode = M_WAIT;
                    end
                end
                m_pos++;
                m_idle = 0;
            end else if (m_idle == TO) begin
                e_ll = 1; m_mode = M_WAIT; e_sidx = '0; e_sym = '0;
            end else begin
                m_idle++;
            end
        end
    endtask

    // One clock: drive at negedge, model the edge, compare at the next negedge.
    task automatic step(input logic v, input logic s, input logic b, input logic init);
        rx_data_valid = v; sync_detect = s; fft_busy = b; sys_init = init;
        model(v, s, b, init);
        @(posedge sys_clk);
        @(negedge sys_clk);
        check("cycle", 32'(pack_dut()), 32'(pack_exp()));
        cnt_valid += int'(fft_sample_valid);
        cnt_start += int'(fft_start);
        cnt_rds   += int'(rx_rcv_data_start);
        cnt_fd    += int'(frame_done);
        cnt_ll    += int'(lost_lock);
    endtask

    task automatic clear_counts();
        cnt_valid = 0; cnt_start = 0; cnt_rds = 0; cnt_fd = 0; cnt_ll = 0;
    endtask

    task automatic run_scen(input int id, input scen_t sc);
        logic s, b;
        int   p;
        step(0, 0, 0, 1);
        clear_counts();
        for (int k = 0; k < sc.nstrobe; k++) begin
            for (int g = 1; g < sc.gap; g++)
                step(0, ($urandom % 2) == 1, ($urandom % 2) == 1, 0);
            p = k - sc.sync_at;
            s = (k == sc.sync_at) || (p > 0 && p < RAW * SPF && ($urandom % 4) == 0);
            if (p >= 0 && p < RAW * SPF && (p % RAW) == G) b = (sc.busy_sym == p / RAW);
            else                                           b = ($urandom % 2) == 1;
            step(1, s, b, 0);
        end
        check($sformatf("scen%0d valid_count", id), cnt_valid, sc.exp_valid);
        check($sformatf("scen%0d start_count", id), cnt_start, sc.exp_start);
        check($sformatf("scen%0d rcv_start_count", id), cnt_rds, sc.exp_rds);
        check($sformatf("scen%0d frame_done_count", id), cnt_fd, sc.exp_fd);
        check($sformatf("scen%0d overflow_err", id), 32'(overflow_err), sc.exp_ovf);
    endtask

    initial begin
        int ll_at;
        vec[0] = '{24,  5,  85, -1,  64, 1, 64, 0, 0};
        vec[1] = '{ 1,  0, 240, -1, 192, 3, 64, 1, 0};
        vec[2] = '{ 2,  3, 263, -1, 192, 3, 64, 1, 0};
        vec[3] = '{ 1,  0, 240,  1, 192, 3, 64, 1, 1};
        vec[4] = '{ 3, 10, 106, -1,  64, 1, 64, 0, 0};
        vec[5] = '{ 1,  2,  99,  1,  65, 2, 64, 0, 1};

        sys_rstn = 0; sys_init = 0; rx_data_valid = 0; sync_detect = 0; fft_busy = 0;
        model_reset();
        clear_counts();
        repeat (3) @(negedge sys_clk);
        check("reset_state", 32'(pack_dut()), 32'h0);
        sys_rstn = 1;

        // Strobes with sync in IDLE are ignored until sys_init.
        repeat (10) step(1, 1, 0, 0);
        check("idle_ignores_sync", cnt_valid, 0);

        for (int i = 0; i < 6; i++) run_scen(i, vec[i]);

        // Strobes stop at sample_idx 30: lost_lock 257 cycles after the last strobe.
        step(0, 0, 0, 1);
        step(1, 1, 0, 0);
        for (int i = 1; i <= 46; i++) step(1, 0, 0, 0);
        check("stall_sample_idx", 32'(sample_idx), 32'd30);
        ll_at = 0;
        for (int k = 1; k <= 300 && ll_at == 0; k++) begin
            step(0, 0, 0, 0);
            if (lost_lock) ll_at = k;
        end
        check("lost_lock_delay", ll_at, 257);
        step(0, 0, 0, 0);
        check("lost_lock_pulse_width", 32'(lost_lock), 32'd0);
        clear_counts();
        repeat (20) step(1, 0, 0, 0);
        check("no_output_after_loss", cnt_valid, 0);

        // A strobe in the timeout cycle resets the watchdog.
        step(0, 0, 0, 1);
        step(1, 1, 0, 0);
        repeat (5) step(1, 0, 0, 0);
        clear_counts();
        repeat (TO) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        check("strobe_in_timeout_cycle", cnt_ll, 0);
        repeat (TO + 1) step(0, 0, 0, 0);
        check("timeout_after_rearm", cnt_ll, 1);

        // sys_init with a strobe in DATA drops the sample and clears counters.
        step(0, 0, 0, 1);
        step(1, 1, 0, 0);
        for (int i = 1; i <= 20; i++) step(1, 0, 0, 0);
        step(1, 0, 0, 1);
        check("init_drops_sample", 32'(fft_sample_valid), 32'd0);
        check("init_clears_idx", 32'({sample_idx, symbol_idx}), 32'd0);
        clear_counts();
        repeat (5) step(1, 0, 0, 0);
        check("init_waits_for_sync", cnt_valid, 0);
        step(1, 1, 0, 0);
        repeat (G) step(1, 0, 0, 0);
        check("resync_first_sample", cnt_start, 1);

        // Asynchronous reset mid-symbol.
        for (int i = 1; i <= 30; i++) step(1, 0, 0, 0);
        #2 sys_rstn = 0;
        #1 check("async_reset_outputs", 32'(pack_dut()), 32'h0);
        model_reset();
        @(negedge sys_clk);
        repeat (3) step(1, 1, 0, 0);
        sys_rstn = 1;
        clear_counts();
        repeat (20) step(1, 1, 0, 0);
        check("after_reset_needs_init", cnt_valid, 0);

        // Randomized traffic with occasional long gaps and restarts.
        step(0, 0, 0, 1);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                int burst;
                burst = $urandom_range(240, 270);
                for (int j = 0; j < burst; j++) step(0, ($urandom % 2) == 1, 0, 0);
            end
            step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 3,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 499) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
